// File: rtl/player_motion_ctrl.sv
// Player token motion controller: walks the sprite along a serpentine board path,
// stepping pixels once per frame_tick. Optional hop lift is enabled by PLAYER_MOTION_HOP_EN.
module player_motion_ctrl #(
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROWS         = 4,
  parameter int unsigned CELL         = 32,
  parameter int unsigned ORIGIN_X     = 64,
  parameter int unsigned ORIGIN_Y     = 96,
  parameter int unsigned STEP_PX      = 2,
  parameter int unsigned PAUSE_FRAMES = 8,
  parameter int unsigned HOP_PX       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       move_start,
  input  logic [2:0] steps,
  input  logic       home,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [4:0] square_idx,
  output logic       busy,
  output logic       move_done,
  output logic       finished
);

  localparam int unsigned NUM_SQ = COLS * ROWS;
  localparam int unsigned PW     = $clog2(PAUSE_FRAMES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MOVE  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [9:0] SQ0_X  = 10'(ORIGIN_X + (CELL - 16) / 2);
  localparam logic [9:0] SQ0_Y  = 10'(ORIGIN_Y + (CELL - 16) / 2);
  localparam logic [9:0] STEP   = 10'(STEP_PX);
  localparam logic [9:0] HOP    = 10'(HOP_PX);
  localparam logic [9:0] HOP_LO = 10'(CELL / 4);
  localparam logic [9:0] HOP_HI = 10'(3 * CELL / 4);
  localparam logic [4:0] LAST   = 5'(NUM_SQ - 1);

`ifdef PLAYER_MOTION_HOP_EN
  localparam bit HOP_EN = 1'b1;
`else
  localparam bit HOP_EN = 1'b0;
`endif

  function automatic logic [9:0] sq_x(input logic [4:0] i);
    int unsigned iv, r, c;
    iv = 32'(i);
    r  = iv / COLS;
    c  = iv % COLS;
    if (r % 2 == 1) c = COLS - 1 - c;
    return 10'(ORIGIN_X + c * CELL + (CELL - 16) / 2);
  endfunction

  function automatic logic [9:0] sq_y(input logic [4:0] i);
    int unsigned iv, r;
    iv = 32'(i);
    r  = iv / COLS;
    return 10'(ORIGIN_Y + r * CELL + (CELL - 16) / 2);
  endfunction

  // Move one STEP toward tgt without overshooting it.
  function automatic logic [9:0] step_to(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] res;
    res = cur;
    if (cur < tgt) res = (tgt - cur > STEP) ? cur + STEP : tgt;
    else if (cur > tgt) res = (cur - tgt > STEP) ? cur - STEP : tgt;
    return res;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    rem_q, rem_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [9:0]    tx_q, tx_d, ty_q, ty_d;
  logic [PW-1:0] pcnt_q, pcnt_d;

  logic [4:0] nxt, space, start_rem;
  logic [9:0] nxt_x, nxt_y;
  logic [9:0] dx, dy, dmov;
  logic       hop;

  always_comb begin
    nxt       = idx_q + 5'd1;
    nxt_x     = sq_x(nxt);
    nxt_y     = sq_y(nxt);
    space     = LAST - idx_q;
    start_rem = ({2'b00, steps} < space) ? {2'b00, steps} : space;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    pcnt_d  = pcnt_q;
    if (home) begin
      state_d = IDLE;
      idx_d   = 5'd0;
      rem_d   = 5'd0;
      x_d     = SQ0_X;
      y_d     = SQ0_Y;
      tx_d    = SQ0_X;
      ty_d    = SQ0_Y;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (move_start) begin
            rem_d = start_rem;
            if (start_rem == 5'd0) begin
              state_d = DONE;
            end else begin
              state_d = MOVE;
              tx_d    = nxt_x;
              ty_d    = nxt_y;
            end
          end
        end
        MOVE: begin
          // Arrival is registered one clk after the last pixel step.
          if (x_q == tx_q && y_q == ty_q) begin
            idx_d   = nxt;
            rem_d   = rem_q - 5'd1;
            pcnt_d  = '0;
            state_d = (rem_q == 5'd1) ? DONE : PAUSE;
          end else if (frame_tick) begin
            x_d = step_to(x_q, tx_q);
            y_d = step_to(y_q, ty_q);
          end
        end
        PAUSE: begin
          if (frame_tick) begin
            if (pcnt_q == PW'(PAUSE_FRAMES - 1)) begin
              pcnt_d  = '0;
              state_d = MOVE;
              tx_d    = nxt_x;
              ty_d    = nxt_y;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      rem_q   <= 5'd0;
      x_q     <= SQ0_X;
      y_q     <= SQ0_Y;
      tx_q    <= SQ0_X;
      ty_q    <= SQ0_Y;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Hop band is judged on the remaining distance along the axis still moving.
  always_comb begin
    dx   = (tx_q > x_q) ? tx_q - x_q : x_q - tx_q;
    dy   = (ty_q > y_q) ? ty_q - y_q : y_q - ty_q;
    dmov = (x_q != tx_q) ? dx : dy;
    hop  = HOP_EN && (state_q == MOVE) && (dmov > HOP_LO) && (dmov <= HOP_HI);
  end

  assign player_x   = x_q;
  assign player_y   = hop ? y_q - HOP : y_q;
  assign square_idx = idx_q;
  assign busy       = (state_q == MOVE) || (state_q == PAUSE);
  assign move_done  = (state_q == DONE);
  assign finished   = (idx_q == LAST);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: directed move table, corner-case
// sequences and randomized moves against a path-level reference model.
module tb_player_motion_ctrl;

  localparam int COLS = 8, ROWS = 4, CELL = 32, ORIGIN_X = 64, ORIGIN_Y = 96;
  localparam int STEP_PX = 2, PAUSE_FRAMES = 8, HOP_PX = 4;
  localparam int NUM_SQ = COLS * ROWS;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_tick = 1'b0, move_start = 1'b0, home = 1'b0;
  logic [2:0] steps = 3'd0;
  logic [9:0] player_x, player_y;
  logic [4:0] square_idx;
  logic       busy, move_done, finished;

  player_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .move_start (move_start),
    .steps      (steps),
    .home       (home),
    .player_x   (player_x),
    .player_y   (player_y),
    .square_idx (square_idx),
    .busy       (busy),
    .move_done  (move_done),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, done_cnt = 0, m_idx = 0;

  always @(negedge clk) if (rst_n && move_done) done_cnt++;

  typedef struct {int x; int y; int idx; bit hop;} pt_t;
  pt_t path[$];

  typedef struct {int st; int gap; int idx; int x; int y; bit fin;} vec_t;
  vec_t vt[10];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int gx(input int i);
    int r, c;
    r = i / COLS;
    c = i % COLS;
    if (r % 2 == 1) c = COLS - 1 - c;
    return ORIGIN_X + c * CELL + (CELL - 16) / 2;
  endfunction

  function automatic int gy(input int i);
    return ORIGIN_Y + (i / COLS) * CELL + (CELL - 16) / 2;
  endfunction

  function automatic int exp_py(input int y, input bit hop);
`ifdef PLAYER_MOTION_HOP_EN
    return hop ? y - HOP_PX : y;
`else
    return y;
`endif
  endfunction

  // Expected (x, y, idx) right after each frame_tick of a k-square move.
  function automatic void build_path(input int start, input int k);
    path.delete();
    for (int s = start; s < start + k; s++) begin
      int x0, y0, x1, y1;
      x0 = gx(s); y0 = gy(s); x1 = gx(s + 1); y1 = gy(s + 1);
      for (int t = 1; t <= CELL / STEP_PX; t++) begin
        pt_t p;
        int  d;
        d     = CELL - t * STEP_PX;
        p.x   = x0 + (x1 - x0) * t * STEP_PX / CELL;
        p.y   = y0 + (y1 - y0) * t * STEP_PX / CELL;
        p.idx = s;
        p.hop = (d > CELL / 4) && (d <= 3 * CELL / 4);
        path.push_back(p);
      end
      if (s < start + k - 1)
        for (int q = 0; q < PAUSE_FRAMES; q++) path.push_back('{x1, y1, s + 1, 1'b0});
    end
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
  endtask

  task automatic do_home();
    home = 1'b1;
    step_clk();
    home = 1'b0;
    m_idx = 0;
    check("home_idx", int'(square_idx), 0);
  endtask

  // inject >= 0: pulse move_start (steps=7) right after that tick index.
  task automatic run_move(input int st, input int gap, input int inject);
    int k, start, d0, wait_n;
    start = m_idx;
    k = (st < NUM_SQ - 1 - m_idx) ? st : NUM_SQ - 1 - m_idx;
    build_path(start, k);
    d0 = done_cnt;
    steps = 3'(st);
    move_start = 1'b1;
    step_clk();
    move_start = 1'b0;
    if (k > 0) check("busy_after_start", int'(busy), 1);
    for (int i = 0; i < path.size(); i++) begin
      repeat (gap - 1) step_clk();
      pulse_tick();
      check("path_x", int'(player_x), path[i].x);
      check("path_y", int'(player_y), exp_py(path[i].y, path[i].hop));
      check("path_idx", int'(square_idx), path[i].idx);
      if (i == inject) begin
        steps = 3'd7;
        move_start = 1'b1;
        step_clk();
        move_start = 1'b0;
      end
    end
    wait_n = 0;
    while (done_cnt == d0 && wait_n < 8) begin
      step_clk();
      wait_n++;
    end
    step_clk();
    step_clk();
    check("done_pulses", done_cnt - d0, 1);
    m_idx = start + k;
    check("end_busy", int'(busy), 0);
    check("end_idx", int'(square_idx), m_idx);
    check("end_x", int'(player_x), gx(m_idx));
    check("end_y", int'(player_y), gy(m_idx));
    check("end_finished", int'(finished), (m_idx == NUM_SQ - 1) ? 1 : 0);
  endtask

  initial begin
    int d0;
    vt[0] = '{3, 100, 3, 168, 104, 1'b0};
    vt[1] = '{4, 3, 7, 296, 104, 1'b0};
    vt[2] = '{1, 3, 8, 296, 136, 1'b0};
    vt[3] = '{0, 3, 8, 296, 136, 1'b0};
    vt[4] = '{5, 2, 13, 136, 136, 1'b0};
    vt[5] = '{7, 3, 20, 200, 168, 1'b0};
    vt[6] = '{7, 2, 27, 200, 200, 1'b0};
    vt[7] = '{2, 4, 29, 136, 200, 1'b0};
    vt[8] = '{6, 3, 31, 72, 200, 1'b1};
    vt[9] = '{5, 3, 31, 72, 200, 1'b1};

    // Reset values.
    repeat (3) step_clk();
    check("rst_x", int'(player_x), 72);
    check("rst_y", int'(player_y), 104);
    rst_n = 1'b1;
    step_clk();
    check("rel_x", int'(player_x), 72);
    check("rel_y", int'(player_y), 104);
    check("rel_idx", int'(square_idx), 0);
    check("rel_busy", int'(busy), 0);
    check("rel_finished", int'(finished), 0);
    check("rel_done", int'(move_done), 0);

    foreach (vt[i]) begin
      run_move(vt[i].st, vt[i].gap, -1);
      check("tbl_idx", int'(square_idx), vt[i].idx);
      check("tbl_x", int'(player_x), vt[i].x);
      check("tbl_y", int'(player_y), vt[i].y);
      check("tbl_fin", int'(finished), int'(vt[i].fin));
    end

    // move_start during MOVE and during PAUSE must be ignored.
    do_home();
    run_move(2, 3, 5);
    run_move(3, 3, 20);

    // Frozen without frame_tick, then home (with move_start) aborts mid-move.
    do_home();
    steps = 3'd3;
    move_start = 1'b1;
    step_clk();
    move_start = 1'b0;
    repeat (5) begin
      step_clk();
      pulse_tick();
    end
    check("mid_x", int'(player_x), 82);
    repeat (20) step_clk();
    check("frozen_x", int'(player_x), 82);
    check("frozen_busy", int'(busy), 1);
    d0 = done_cnt;
    steps = 3'd5;
    home = 1'b1;
    move_start = 1'b1;
    step_clk();
    home = 1'b0;
    move_start = 1'b0;
    m_idx = 0;
    check("abort_idx", int'(square_idx), 0);
    check("abort_x", int'(player_x), 72);
    check("abort_y", int'(player_y), 104);
    check("abort_busy", int'(busy), 0);
    repeat (6) step_clk();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", int'(busy), 0);

    // Asynchronous reset mid-move.
    steps = 3'd4;
    move_start = 1'b1;
    step_clk();
    move_start = 1'b0;
    repeat (10) begin
      step_clk();
      pulse_tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", int'(player_x), 72);
    check("arst_y", int'(player_y), 104);
    check("arst_busy", int'(busy), 0);
    step_clk();
    rst_n = 1'b1;
    step_clk();
    m_idx = 0;

    // Randomized moves.
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) == 0 || m_idx >= 28) do_home();
      run_move(int'($urandom_range(0, 7)), int'($urandom_range(2, 5)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
